nfc_mif_rdq: RTL

- Parametrised next-generation read-side memory interface of the NAND flash controller (NFC).
- Streams one page-program payload from the page RAM / RNG / ECC encoder to the NF_IF byte/word engine, multi-sector: per sector DAT -> SPA -> ECC phases, repeated nfc_sect_cnt times.
- Supports 8- and 16-bit flash bus, fully pipelined back-to-back reads with fixed latency, and abort.
- Sits between the NFC SFR block, nfc_if, the ECC encoder and the page SRAM.

---
 rtl/nfc_mif_pkg.sv | 31 +++
 rtl/nfc_mif_rdpipe.sv | 68 ++++++
 rtl/nfc_mif_rdq.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/nfc_mif_pkg.sv
// Shared types and constants for the NFC read-side memory interface.
package nfc_mif_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DAT  = 3'd1,
    ST_SPA  = 3'd2,
    ST_ECC  = 3'd3,
    ST_DONE = 3'd4
  } mif_st_e;

  typedef enum logic [1:0] {
    SRC_RAM = 2'd0,
    SRC_RNG = 2'd1,
    SRC_ECC = 2'd2
  } src_e;

  localparam int ECC_LEN_18 = 18;
  localparam int ECC_LEN_25 = 25;
  localparam int PIPE_LAT   = 2;

  // ECC beat count from the 2-bit length code; 00 and 11 mean no ECC phase
  function automatic logic [4:0] ecc_beats(input logic [1:0] sel);
    case (sel)
      2'b01:   ecc_beats = 5'(ECC_LEN_18);
      2'b10:   ecc_beats = 5'(ECC_LEN_25);
      default: ecc_beats = 5'd0;
    endcase
  endfunction

endpackage

// File: rtl/nfc_mif_rdpipe.sv
// Two-stage beat pipeline: stage 1 captures source/byte-select (and the RNG
// word at pop time), stage 2 muxes the returning word and presents the beat.
module nfc_mif_rdpipe
  import nfc_mif_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        acc,
  input  src_e        src,
  input  logic        byte_sel,
  input  logic        bus16,
  input  logic [15:0] rng_dat,
  input  logic [15:0] ram_dout,
  input  logic [15:0] ecc_dat,
  output logic        rd_rdy,
  output logic [15:0] data
);

  logic [PIPE_LAT:1] vld_pipe;
  src_e              s1_src;
  logic              s1_bsel;
  logic              s1_b16;
  logic [15:0]       s1_rng;
  logic [15:0]       word;
  logic [15:0]       beat;

  // valid shift register; an abort empties every stage
  always_ff @(posedge clk or posedge rst)
    if (rst)        vld_pipe <= '0;
    else if (flush) vld_pipe <= '0;
    else            vld_pipe <= {vld_pipe[PIPE_LAT-1:1], acc};

  // stage 1: remember where the beat comes from; bus width travels with it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_src  <= SRC_RAM;
      s1_bsel <= 1'b0;
      s1_b16  <= 1'b0;
      s1_rng  <= '0;
    end else if (acc) begin
      s1_src  <= src;
      s1_bsel <= byte_sel;
      s1_b16  <= bus16;
      s1_rng  <= rng_dat;
    end

  // select the returning word and narrow it to a byte in 8-bit mode
  always_comb begin
    word = ram_dout;
    case (s1_src)
      SRC_RNG: word = s1_rng;
      SRC_ECC: word = ecc_dat;
      default: word = ram_dout;
    endcase
    if (s1_b16)                             beat = word;
    else if (s1_src == SRC_RAM && s1_bsel)  beat = {8'h00, word[15:8]};
    else                                    beat = {8'h00, word[7:0]};
  end

  // stage 2: data register holds its value between beats
  always_ff @(posedge clk or posedge rst)
    if (rst)                        data <= '0;
    else if (vld_pipe[1] && !flush) data <= beat;

  assign rd_rdy = vld_pipe[PIPE_LAT];

endmodule

// File: rtl/nfc_mif_rdq.sv
// NFC read-side memory interface: sequences DAT/SPA/ECC phases per sector
// and streams beats from page RAM, RNG or ECC encoder to nf_if.
module nfc_mif_rdq
  import nfc_mif_pkg::*;
#(
  parameter int ADDR_WID = 14,
  parameter int BLK_W    = 12,
  parameter int SECT_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nfc_start,
  input  logic                nfc_abort,
  input  logic                nfc_bus16,
  input  logic                nfc_rng_en,
  input  logic                nfc_spa_en,
  input  logic                nfc_ecc_en,
  input  logic [BLK_W-1:0]    nfc_blk_len,
  input  logic [3:0]          nfc_spa_len,
  input  logic [1:0]          nfc_ecc_len,
  input  logic [SECT_W-1:0]   nfc_sect_cnt,
  input  logic [ADDR_WID-1:0] nfc_dat_addr,
  input  logic [ADDR_WID-1:0] nfc_spa_addr,
  output logic                mif_busy,
  output logic                mif_done,
  input  logic                nfif_data_rd,
  output logic                nfif_rd_rdy,
  output logic [15:0]         nfif_data_in,
  output logic                rng_rd,
  input  logic [15:0]         rng_dat,
  output logic                mif_ecc_rd,
  input  logic [15:0]         ecc_enc_dat,
  output logic [ADDR_WID-2:0] nfc_ram_addr,
  output logic                nfc_ram_cen,
  output logic [1:0]          nfc_ram_wen,
  input  logic [15:0]         ram_nfc_dout
);

  mif_st_e             state, state_nxt, first_ph, sect_end_ph, ph_after;
  logic [BLK_W-1:0]    beat_cnt, cur_len, spa_len_w, ecc_len_w;
  logic [SECT_W-1:0]   sect_cnt, sect_last;
  logic [ADDR_WID-1:0] dat_ptr, spa_ptr, step, cur_ptr;
  logic                bus16_q, active, acc, last_beat, leave_sect;
  logic                dat_on, spa_on, ecc_on, ram_ph;
  src_e                src;

  assign nfc_ram_wen = 2'b11;
  assign active      = (state == ST_DAT) || (state == ST_SPA) || (state == ST_ECC);
  assign acc         = nfif_data_rd & active & ~nfc_abort;
  assign spa_len_w   = BLK_W'(nfc_spa_len);
  assign ecc_len_w   = BLK_W'(ecc_beats(nfc_ecc_len));
  assign dat_on      = (nfc_blk_len != '0);
  assign spa_on      = nfc_spa_en && (nfc_spa_len != '0);
  assign ecc_on      = nfc_ecc_en && (ecc_len_w != '0);
  assign sect_last   = (nfc_sect_cnt == '0) ? '0 : nfc_sect_cnt - SECT_W'(1);
  assign step        = bus16_q ? ADDR_WID'(2) : ADDR_WID'(1);
  assign ram_ph      = ((state == ST_DAT) && !nfc_rng_en) || (state == ST_SPA);
  assign cur_ptr     = (state == ST_SPA) ? spa_ptr : dat_ptr;
  assign last_beat   = (beat_cnt == cur_len - BLK_W'(1));

  // phase sequencing: empty or disabled phases are skipped without a cycle
  always_comb begin
    first_ph = ST_DONE;
    if (ecc_on) first_ph = ST_ECC;
    if (spa_on) first_ph = ST_SPA;
    if (dat_on) first_ph = ST_DAT;
    if (sect_cnt == sect_last) sect_end_ph = ST_DONE;
    else                       sect_end_ph = first_ph;
    cur_len    = '0;
    ph_after   = sect_end_ph;
    leave_sect = 1'b1;
    case (state)
      ST_DAT: begin
        cur_len = nfc_blk_len;
        if (spa_on)      begin ph_after = ST_SPA; leave_sect = 1'b0; end
        else if (ecc_on) begin ph_after = ST_ECC; leave_sect = 1'b0; end
      end
      ST_SPA: begin
        cur_len = spa_len_w;
        if (ecc_on) begin ph_after = ST_ECC; leave_sect = 1'b0; end
      end
      ST_ECC:  cur_len = ecc_len_w;
      default: ;
    endcase
  end

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;

  // next state; abort wins over everything
  always_comb begin
    state_nxt = state;
    if (nfc_abort) state_nxt = ST_IDLE;
    else case (state)
      ST_IDLE: if (nfc_start) state_nxt = first_ph;
      ST_DAT, ST_SPA, ST_ECC: if (acc && last_beat) state_nxt = ph_after;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // outputs and source select
  always_comb begin
    mif_busy     = (state != ST_IDLE);
    mif_done     = (state == ST_DONE);
    rng_rd       = acc & (state == ST_DAT) & nfc_rng_en;
    mif_ecc_rd   = acc & (state == ST_ECC);
    nfc_ram_cen  = ~(acc & ram_ph);
    nfc_ram_addr = cur_ptr[ADDR_WID-1:1];
    src          = SRC_RAM;
    if (state == ST_ECC)                    src = SRC_ECC;
    else if (state == ST_DAT && nfc_rng_en) src = SRC_RNG;
  end

  // beat/sector counters and byte pointers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus16_q  <= 1'b0;
      beat_cnt <= '0;
      sect_cnt <= '0;
      dat_ptr  <= '0;
      spa_ptr  <= '0;
    end else if (nfc_abort) begin
      beat_cnt <= '0;
    end else if (state == ST_IDLE && nfc_start) begin
      bus16_q  <= nfc_bus16;
      beat_cnt <= '0;
      sect_cnt <= '0;
      dat_ptr  <= nfc_dat_addr;
      spa_ptr  <= nfc_spa_addr;
    end else if (acc) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + BLK_W'(1);
      if (last_beat && leave_sect)   sect_cnt <= sect_cnt + SECT_W'(1);
      if (ram_ph && state == ST_DAT) dat_ptr  <= dat_ptr + step;
      if (state == ST_SPA)           spa_ptr  <= spa_ptr + step;
    end

  nfc_mif_rdpipe u_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (nfc_abort),
    .acc      (acc),
    .src      (src),
    .byte_sel (cur_ptr[0]),
    .bus16    (bus16_q),
    .rng_dat  (rng_dat),
    .ram_dout (ram_nfc_dout),
    .ecc_dat  (ecc_enc_dat),
    .rd_rdy   (nfif_rd_rdy),
    .data     (nfif_data_in)
  );

endmodule
